mpe_weight_sequencer: RTL and testbench

//  Upstream feeder of the MPE shift-add multiplier. Accepts a stream of sorted weights, converts each to a

---
 rtl/mpe_pkg.sv | 40 ++++
 rtl/mpe_weight_sequencer_if.sv | 40 ++++
 rtl/mpe_seq_fifo.sv | 46 ++++
 rtl/mpe_weight_sequencer.sv | 132 +++++++++++++
 tb/tb_mpe_weight_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpe_pkg.sv
// -----------------------------------------------------------------------------
// mpe_pkg
//  Shared types and sizes for the MPE weight sequencer slice.
//   BIN_LEN    : weight width, taken from the `BIN_LEN macro (default 8); it must
//                match the shift-add multiplier's weight width.
//   TAG_LEN    : result tag width.
//   FIFO_DEPTH : default issue FIFO depth (power of two, >= 2).
//  seq_entry_t : one buffered issue {val, abs, tag}.
//  seq_state_e : issue FSM states.
//  bitlen()    : index of the highest set bit + 1 (0 for 0); this is the
//                number of shift cycles the multiplier spends on a value.
// -----------------------------------------------------------------------------
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

package mpe_pkg;
    localparam int BIN_LEN    = `BIN_LEN;
    localparam int TAG_LEN    = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [BIN_LEN-1:0] val;
        logic               abs;
        logic [TAG_LEN-1:0] tag;
    } seq_entry_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_WAIT = 1'b1
    } seq_state_e;

    function automatic int bitlen(input logic [BIN_LEN-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < BIN_LEN; i++)
            if (v[i]) n = i + 1;
        return n;
    endfunction
endpackage

// File: rtl/mpe_weight_sequencer_if.sv
// -----------------------------------------------------------------------------
// mpe_weight_sequencer_if
//  Bundles the three channels of the weight sequencer:
//   in_*  : weight input stream (valid/ready)
//   mul_* : issue channel towards the shift-add multiplier (ready/enable)
//   res_* : tagged result strobe, plus busy
//  Modports:
//   slave  : the sequencer itself
//   master : the environment (weight source, multiplier, result consumer)
// -----------------------------------------------------------------------------
interface mpe_weight_sequencer_if;
    import mpe_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BIN_LEN-1:0] in_weight;
    logic               in_first;
    logic [TAG_LEN-1:0] in_tag;

    logic               mul_ready;
    logic               mul_enable;
    logic [BIN_LEN-1:0] mul_weight_val;
    logic               mul_weight_abs;

    logic               res_valid;
    logic [TAG_LEN-1:0] res_tag;
    logic               busy;

    modport slave (
        input  in_valid, in_weight, in_first, in_tag, mul_ready,
        output in_ready, mul_enable, mul_weight_val, mul_weight_abs,
               res_valid, res_tag, busy
    );

    modport master (
        output in_valid, in_weight, in_first, in_tag, mul_ready,
        input  in_ready, mul_enable, mul_weight_val, mul_weight_abs,
               res_valid, res_tag, busy
    );
endinterface

// File: rtl/mpe_seq_fifo.sv
// -----------------------------------------------------------------------------
// mpe_seq_fifo
//  Synchronous FIFO of seq_entry_t with a show-ahead head.
//  Ports:
//   clock, reset   : rising-edge clock, async active-low reset (pointers only)
//   push / wr_data : write when not full
//   pop  / rd_data : rd_data is the current head; pop advances when not empty
//   full, empty    : derived from the registered pointers only
// -----------------------------------------------------------------------------
module mpe_seq_fifo import mpe_pkg::*; #(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  seq_entry_t wr_data,
    input  logic       pop,
    output seq_entry_t rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    seq_entry_t    mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/mpe_weight_sequencer.sv
// -----------------------------------------------------------------------------
// mpe_weight_sequencer
//  Feeds the MPE shift-add multiplier. Sorted weights arrive on bus.in_*, are
//  turned into a delta against the previous weight (or an absolute restart on
//  in_first / a descending weight), buffered, and issued using the multiplier's
//  out_ready/enable protocol. res_valid/res_tag pulse when the multiplier's
//  outputs are final for an issued entry.
//  Ports:
//   clock, reset : rising-edge clock, async active-low reset
//   bus (slave)  : in_valid/in_ready/in_weight/in_first/in_tag,
//                  mul_ready/mul_enable/mul_weight_val/mul_weight_abs,
//                  res_valid/res_tag, busy
//  Build option MPE_SEQ_ZERO_SKIP_EN: zero deltas are retired without touching
//  the multiplier (result pulses the cycle after the pop, enable stays low).
// -----------------------------------------------------------------------------
module mpe_weight_sequencer import mpe_pkg::*; (
    input  logic                         clock,
    input  logic                         reset,
    mpe_weight_sequencer_if.slave        bus
);
    seq_entry_t         in_ent;
    seq_entry_t         head;
    logic               full, empty, push, pop;
    logic               rdy_q, in_ready_w;
    logic [BIN_LEN-1:0] prev_w;
    seq_state_e         state, state_nxt;
    logic [TAG_LEN-1:0] cur_tag, skip_tag;
    logic               skip_vld, skip_set;
    logic               issue, shift_en, res_now, head_skip;

    // rdy_q keeps in_ready low while reset is held and for the first edge after.
    assign in_ready_w = rdy_q && !full;
    assign push       = bus.in_valid && in_ready_w;

    always_comb begin
        in_ent.abs = bus.in_first || (bus.in_weight < prev_w);
        in_ent.val = in_ent.abs ? bus.in_weight : bus.in_weight - prev_w;
        in_ent.tag = bus.in_tag;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_w <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) prev_w <= bus.in_weight;
        end
    end

    mpe_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (in_ent),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

`ifdef MPE_SEQ_ZERO_SKIP_EN
    assign head_skip = !empty && (head.val == '0) && !head.abs;
`else
    assign head_skip = 1'b0;
`endif

    // The multiplier's outputs are final exactly when it reports ready again,
    // so a result and the next load can share a cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pop       = 1'b0;
        skip_set  = 1'b0;
        shift_en  = 1'b0;
        res_now   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (bus.mul_ready && !empty) begin
                    pop = 1'b1;
                    if (head_skip) begin
                        skip_set = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = SEQ_WAIT;
                    end
                end
            end
            SEQ_WAIT: begin
                if (!bus.mul_ready) begin
                    shift_en = 1'b1;
                end else begin
                    res_now = 1'b1;
                    if (!empty && !head_skip) begin
                        pop   = 1'b1;
                        issue = 1'b1;
                    end else begin
                        state_nxt = SEQ_IDLE;
                        if (!empty) begin
                            pop      = 1'b1;
                            skip_set = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SEQ_IDLE;
            cur_tag  <= '0;
            skip_vld <= 1'b0;
            skip_tag <= '0;
        end else begin
            state    <= state_nxt;
            skip_vld <= skip_set;
            if (issue)    cur_tag  <= head.tag;
            if (skip_set) skip_tag <= head.tag;
        end
    end

    assign bus.in_ready       = in_ready_w;
    assign bus.mul_enable     = issue || shift_en;
    assign bus.mul_weight_val = issue ? head.val : '0;
    assign bus.mul_weight_abs = issue && head.abs;
    // A skip pulse always lands in IDLE, so it never coincides with res_now.
    assign bus.res_valid      = res_now || skip_vld;
    assign bus.res_tag        = skip_vld ? skip_tag : (res_now ? cur_tag : '0);
    assign bus.busy           = !empty || (state == SEQ_WAIT) || skip_vld;
endmodule

// File: tb/tb_mpe_weight_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mpe_weight_sequencer
//  Drives mpe_weight_sequencer against a behavioural shift-add multiplier and
//  checks every load, result tag, product and latency against a queue-based
//  reference built from the weight/delta rules.
// -----------------------------------------------------------------------------
module tb_mpe_weight_sequencer;
    import mpe_pkg::*;

`ifdef MPE_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mpe_weight_sequencer_if sif();

    mpe_weight_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Behavioural multiplier: loads when its weight register is zero, then
    // consumes one weight bit per enabled cycle. hold forces it not-ready.
    logic               hold = 1'b0;
    int unsigned        mx   = 1;
    logic [BIN_LEN-1:0] mw;
    int unsigned        macc;
    int                 msh;

    assign sif.mul_ready = (mw == '0) && !hold;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mw   <= '0;
            macc <= 0;
            msh  <= 0;
        end else if (!hold && sif.mul_enable) begin
            if (mw == '0) begin
                mw  <= sif.mul_weight_val;
                msh <= 0;
                if (sif.mul_weight_abs) macc <= 0;
            end else begin
                if (mw[0]) macc <= macc + (mx << msh);
                mw  <= mw >> 1;
                msh <= msh + 1;
            end
        end
    end

    // Reference model
    typedef struct {
        int w;
        int val;
        bit abs;
        int tag;
        bit skip;
    } ref_t;

    ref_t iss_q[$];
    ref_t res_q[$];
    int   fly_q[$];
    int   prev_ref = 0;
    int   accepted = 0;
    bit   hold_seen = 1'b0;
    int   ld_val[$], ld_abs[$], rs_acc[$], rs_tag[$], rs_lat[$];

    always @(negedge clock) begin
        ref_t e;
        int   lat;
        if (!reset) begin
            iss_q.delete(); res_q.delete(); fly_q.delete();
            prev_ref = 0;
        end else begin
            if (sif.res_valid) begin
                if (res_q.size() == 0) chk("spurious_res", 1, 0);
                else begin
                    e = res_q.pop_front();
                    chk("res_tag", sif.res_tag, e.tag);
                    chk("res_acc", macc, mx * e.w);
                    rs_acc.push_back(int'(macc));
                    rs_tag.push_back(int'(sif.res_tag));
                    if (!e.skip && fly_q.size() > 0) begin
                        lat = cyc - fly_q.pop_front();
                        rs_lat.push_back(lat);
                        if (!hold_seen) chk("latency", lat, 1 + $clog2(e.val + 1));
                    end
                end
            end
            if (sif.mul_enable && sif.mul_ready) begin
                if (iss_q.size() == 0) chk("spurious_load", 1, 0);
                else begin
                    e = iss_q.pop_front();
                    chk("ld_val", sif.mul_weight_val, e.val);
                    chk("ld_abs", sif.mul_weight_abs, e.abs);
                    ld_val.push_back(int'(sif.mul_weight_val));
                    ld_abs.push_back(int'(sif.mul_weight_abs));
                    fly_q.push_back(cyc);
                end
            end else if (sif.mul_ready && iss_q.size() == 0) begin
                chk("idle_enable", sif.mul_enable, 0);
            end
            if (sif.in_valid && sif.in_ready) begin
                e.w    = int'(sif.in_weight);
                e.tag  = int'(sif.in_tag);
                e.abs  = sif.in_first || (e.w < prev_ref);
                e.val  = e.abs ? e.w : e.w - prev_ref;
                e.skip = SKIP && (e.val == 0) && !e.abs;
                prev_ref = e.w;
                res_q.push_back(e);
                if (!e.skip) iss_q.push_back(e);
                accepted++;
            end
        end
    end

    task automatic clear_logs();
        ld_val.delete(); ld_abs.delete(); rs_acc.delete(); rs_tag.delete(); rs_lat.delete();
    endtask

    task automatic push(input int w, input bit first, input int tag);
        bit ok;
        ok = 1'b0;
        sif.in_valid  = 1'b1;
        sif.in_weight = BIN_LEN'(w);
        sif.in_first  = first;
        sif.in_tag    = TAG_LEN'(tag);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (sif.in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clock); #1;
        sif.in_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (res_q.size() == 0 && !sif.busy) begin ok = 1'b1; break; end
        end
        @(posedge clock); #1;
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, pw;
        bit f;
        sif.in_valid = 1'b0; sif.in_weight = '0; sif.in_first = 1'b0; sif.in_tag = '0;

        // reset state
        #2;
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_enable", sif.mul_enable, 0);
        chk("rst_val", sif.mul_weight_val, 0);
        chk("rst_abs", sif.mul_weight_abs, 0);
        chk("rst_res_valid", sif.res_valid, 0);
        chk("rst_res_tag", sif.res_tag, 0);
        chk("rst_busy", sif.busy, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_in_ready", sif.in_ready, 1);

        // 1: group 10,12,13
        mx = 3; clear_logs();
        push(10, 1, 0); push(12, 0, 1); push(13, 0, 2);
        wait_idle();
        chk("t1_n", rs_acc.size(), 3);
        if (rs_acc.size() == 3 && ld_val.size() == 3) begin
            chk("t1_v0", ld_val[0], 10); chk("t1_a0", ld_abs[0], 1);
            chk("t1_v1", ld_val[1], 2);  chk("t1_a1", ld_abs[1], 0);
            chk("t1_v2", ld_val[2], 1);  chk("t1_a2", ld_abs[2], 0);
            chk("t1_o0", rs_acc[0], 30); chk("t1_o1", rs_acc[1], 36); chk("t1_o2", rs_acc[2], 39);
            chk("t1_g2", rs_tag[2], 2);
        end

        // 2: latency of 5 and 255
        mx = 1; clear_logs();
        push(5, 1, 3); wait_idle();
        chk("t2_n5", rs_lat.size(), 1);
        if (rs_lat.size() == 1) chk("t2_lat5", rs_lat[0], 4);
        clear_logs();
        push(255, 1, 4); wait_idle();
        chk("t2_n255", rs_lat.size(), 1);
        if (rs_lat.size() == 1) chk("t2_lat255", rs_lat[0], 9);

        // 3: unsorted restart
        mx = 4; clear_logs();
        push(20, 1, 5); push(7, 0, 6); wait_idle();
        chk("t3_n", ld_val.size(), 2);
        if (ld_val.size() == 2 && rs_acc.size() == 2) begin
            chk("t3_val", ld_val[1], 7); chk("t3_abs", ld_abs[1], 1); chk("t3_out", rs_acc[1], 28);
        end

        // 4: back-pressure with the multiplier held busy
        mx = 2; clear_logs(); accepted = 0;
        hold = 1'b1; hold_seen = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) push(30 + i * 5, i == 0, 10 + i);
            end
        join_none
        repeat (12) @(posedge clock);
        #1;
        chk("t4_accepted", accepted, 4);
        chk("t4_in_ready", sif.in_ready, 0);
        hold = 1'b0;
        wait fork;
        wait_idle();
        hold_seen = 1'b0;
        chk("t4_n", rs_tag.size(), 6);
        for (int i = 0; i < rs_tag.size(); i++) chk("t4_order", rs_tag[i], 10 + i);

        // 5: duplicate weight -> zero delta
        mx = 5; clear_logs();
        push(9, 1, 20); push(9, 0, 21); wait_idle();
        chk("t5_nres", rs_acc.size(), 2);
        if (rs_acc.size() == 2) chk("t5_out", rs_acc[1], 45);
`ifdef MPE_SEQ_ZERO_SKIP_EN
        chk("t5_nload", ld_val.size(), 1);
`else
        chk("t5_nload", ld_val.size(), 2);
        if (ld_val.size() == 2 && rs_lat.size() == 2) begin
            chk("t5_val", ld_val[1], 0); chk("t5_abs", ld_abs[1], 0); chk("t5_lat", rs_lat[1], 1);
        end
`endif

        // 6: reset while a weight of 200 is in flight
        mx = 1; clear_logs();
        push(200, 1, 30);
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t6_enable", sif.mul_enable, 0);
        chk("t6_val", sif.mul_weight_val, 0);
        chk("t6_abs", sif.mul_weight_abs, 0);
        chk("t6_res_valid", sif.res_valid, 0);
        chk("t6_res_tag", sif.res_tag, 0);
        chk("t6_busy", sif.busy, 0);
        chk("t6_in_ready", sif.in_ready, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        mx = 3; clear_logs();
        push(10, 1, 31); push(12, 0, 32); wait_idle();
        chk("t6_n", rs_acc.size(), 2);
        if (rs_acc.size() == 2) begin
            chk("t6_o0", rs_acc[0], 30); chk("t6_o1", rs_acc[1], 36);
        end

        // random streams
        for (int r = 0; r < 3; r++) begin
            mx = $urandom_range(1, 255);
            pw = 0;
            for (int i = 0; i < 40; i++) begin
                f = (i == 0) || ($urandom_range(0, 7) == 0);
                if (f) w = $urandom_range(0, 255);
                else if ($urandom_range(0, 9) == 0) w = $urandom_range(0, 255);
                else begin
                    w = pw + $urandom_range(0, 30);
                    if (w > 255) w = 255;
                end
                pw = w;
                repeat ($urandom_range(0, 2)) @(posedge clock);
                #1;
                push(w, f, (r * 40 + i) & 255);
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
